sync_strobe_gen: RTL and testbench
==================================

Name: sync_strobe_gen

Overview:
- Single-clock, multi-channel successor to the team's sync-distribution logic.
- Replaces per-domain clocks with per-channel clock-enable (CE) strobes derived from sys_clk.
- Detects rising edges of a system sync request and emits one aligned sync strobe per channel after a programmable number of that channel's CE ticks.
- Sits between the acquisition controller (i_sync source) and the pulser/ADC-rate datapaths, which consume o_ce/o_sync.

Parameters:
- CHANNELS, 3, number of independent output channels.
- DIV_W, 8, width of per-channel CE divide ratio.
- DLY_W, 16, width of per-channel delay, counted in CE ticks.
- ALIGN, 1, 1 = realign all CE phase counters on each accepted sync edge; 0 = CE counters free-run from reset.

Ports:
- sys_clk  in  1  system clock, 100 MHz. Reset is synchronous and active-high.
- rst  in  1  synchronous reset, active-high.
- i_sync  in  1  sync request level, sys_clk domain; rising edge triggers.
- i_retrig_en  in  1  1 = a new edge while a channel is armed restarts that channel's delay.
- i_div  in  CHANNELS*DIV_W  per-channel divide ratio N; CE every N cycles; N=0 behaves as N=1.
- i_dly  in  CHANNELS*DLY_W  per-channel delay D, in CE ticks.
- o_ce  out  CHANNELS  per-channel clock-enable strobe, one cycle wide.
- o_sync  out  CHANNELS  per-channel sync strobe; always coincident with that channel's o_ce.
- o_sys_sync  out  1  one-cycle pulse marking an accepted edge.
- o_busy  out  1  OR of all channel armed flags.
- o_overrun  out  1  sticky; set when an edge arrives while any channel is armed and i_retrig_en=0.

Behaviour:
- Reset values:
  - All outputs 0.
  - prev_sync = 1, so i_sync already high at reset release is not treated as an edge.
  - Phase counters 0; all channels IDLE.
- Reset mid-operation: armed channels drop to IDLE with no strobe; o_overrun cleared.
- Edge detect: edge at cycle T when i_sync=1 and prev_sync=0. All outputs are registered. o_sys_sync is high at T+1.
- CE generation, per channel, Neff = max(i_div,1):
  - Phase counter counts 0..Neff-1; o_ce is high in the cycle the counter wraps.
  - Wrap condition is phase >= Neff-1, so lowering i_div on the fly never stalls.
  - i_div is sampled continuously.
- ALIGN=1: on an edge at T, every phase counter is forced so that o_ce=1 at T+1. Later CEs follow at T+1+k*Neff.
- Channel FSM:
  - IDLE: on edge at T, capture i_dly into cnt and go to ARMED (armed visible at T+1). i_dly is sampled only at T.
  - ARMED: on each cycle with o_ce=1:
    - cnt==0: assert o_sync in that same cycle, return to IDLE.
    - otherwise: cnt decrements.
  - The channel therefore fires on the (D+1)-th CE at or after T+1.
- Edge while ARMED:
  - i_retrig_en=1: reload cnt from i_dly, stay ARMED. If this coincides with the firing CE, the reload wins and there is no strobe.
  - i_retrig_en=0: edge ignored for armed channels. IDLE channels still arm. o_overrun set. o_sys_sync still pulses.
- Widths: cnt is DLY_W bits and never wraps below 0. Phase is DIV_W bits. D max = 2^DLY_W-1.
- o_busy: high from T+1 until the cycle after the last channel fires.

Decomposition:
- Package dscope_sync_pkg holds:
  - channel state enum {ST_IDLE, ST_ARMED};
  - default width constants;
  - function div_eff (maps 0 to 1).
- Sub-module sync_strobe_chan holds one channel's phase counter, delay counter and FSM. The top instantiates it CHANNELS times via generate and owns the edge detect, o_sys_sync, o_busy and o_overrun.

Test Plan:
- ALIGN=1, div={1,4,8}, dly={0,0,0}, edge at T -> o_sys_sync at T+1; o_sync of all channels at T+1, each with its o_ce.
- ALIGN=1, div={1,4,8}, dly={3,2,1} -> ch0 fires T+4, ch1 fires T+9, ch2 fires T+9; o_busy high T+1..T+9, low at T+10.
- ALIGN=0, div=4, phase at edge such that the next CE is at T+3, dly=0 -> o_sync at T+3.
- ch0 div=2, dly=5: second edge 4 cycles after the first with i_retrig_en=1 -> fires 10 cycles after the second o_sys_sync. Same with i_retrig_en=0 -> fires on the original schedule and o_overrun=1.
- i_sync held high through reset release -> no o_sys_sync. rst asserted while armed -> o_sync stays 0, o_busy=0 the next cycle.
- div=0 -> o_ce every cycle. div changed 8->2 while phase=5 -> CE next cycle, then every 2 cycles.

Source files
------------

// File: rtl/dscope_sync_pkg.sv
// Shared types, default widths and helpers for the channelised sync strobe generator.
package dscope_sync_pkg;

  localparam int unsigned CHANNELS_DEF = 3;
  localparam int unsigned DIV_W_DEF    = 8;
  localparam int unsigned DLY_W_DEF    = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } chan_state_e;

  // A divide ratio of zero is treated as one so a channel never stops ticking.
  function automatic int unsigned div_eff(input int unsigned n);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction

endpackage

// File: rtl/sync_strobe_chan.sv
// One output channel: CE phase counter, delay counter and the armed/idle FSM.
//   state    | meaning
//   ST_IDLE  | no sync pending, waiting for an accepted edge
//   ST_ARMED | counting CE ticks down to the CE-aligned sync strobe
module sync_strobe_chan
  import dscope_sync_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned DLY_W = DLY_W_DEF,
  parameter bit          ALIGN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             edge_i,
  input  logic             retrig_en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DLY_W-1:0] dly_i,
  output logic             ce_o,
  output logic             sync_o,
  output logic             armed_o,
  output logic             busy_nxt_o
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);

  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] neff;
  logic             ce_q, ce_d;
  logic             sync_q, sync_d;
  chan_state_e      state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] cnt_src;
  logic             arm_now;

  // ce_d is the CE that becomes visible next cycle; the FSM decides on it so
  // the registered o_sync lands in the same cycle as its o_ce.
  always_comb begin
    neff    = DIV_W'(div_eff(32'(div_i)));
    phase_d = phase_q + DIV_ONE;
    ce_d    = 1'b0;
    if (ALIGN && edge_i) begin
      phase_d = '0;
      ce_d    = 1'b1;
    end else if (phase_q >= neff - DIV_ONE) begin
      phase_d = '0;
      ce_d    = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sync_d  = 1'b0;
    arm_now = 1'b0;
    unique case (state_q)
      ST_IDLE:  arm_now = edge_i;
      ST_ARMED: arm_now = edge_i && retrig_en_i;
      default:  arm_now = 1'b0;
    endcase
    cnt_src = arm_now ? dly_i : cnt_q;
    if (arm_now || state_q == ST_ARMED) begin
      state_d = ST_ARMED;
      cnt_d   = cnt_src;
      if (ce_d) begin
        if (cnt_src == '0) begin
          state_d = ST_IDLE;
          sync_d  = 1'b1;
        end else begin
          cnt_d = cnt_src - DLY_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      ce_q    <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      ce_q    <= ce_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ce_o       = ce_q;
  assign sync_o     = sync_q;
  assign armed_o    = (state_q == ST_ARMED);
  assign busy_nxt_o = (state_d == ST_ARMED) || sync_d;

endmodule

// File: rtl/sync_strobe_gen.sv
// Multi-channel sync strobe generator: detects sync request edges and fans
// them out as CE-aligned, per-channel delayed sync strobes.
module sync_strobe_gen
  import dscope_sync_pkg::*;
#(
  parameter int unsigned CHANNELS = CHANNELS_DEF,
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned DLY_W    = DLY_W_DEF,
  parameter int unsigned ALIGN    = 1
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      i_sync,
  input  logic                      i_retrig_en,
  input  logic [CHANNELS*DIV_W-1:0] i_div,
  input  logic [CHANNELS*DLY_W-1:0] i_dly,
  output logic [CHANNELS-1:0]       o_ce,
  output logic [CHANNELS-1:0]       o_sync,
  output logic                      o_sys_sync,
  output logic                      o_busy,
  output logic                      o_overrun
);

  logic                prev_q;
  logic                sys_sync_q;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                edge_det;
  logic [CHANNELS-1:0] armed;
  logic [CHANNELS-1:0] busy_nxt;

  assign edge_det = i_sync & ~prev_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    sync_strobe_chan #(
      .DIV_W (DIV_W),
      .DLY_W (DLY_W),
      .ALIGN (ALIGN != 0)
    ) u_chan (
      .clk_i       (sys_clk),
      .rst_i       (rst),
      .edge_i      (edge_det),
      .retrig_en_i (i_retrig_en),
      .div_i       (i_div[g*DIV_W +: DIV_W]),
      .dly_i       (i_dly[g*DLY_W +: DLY_W]),
      .ce_o        (o_ce[g]),
      .sync_o      (o_sync[g]),
      .armed_o     (armed[g]),
      .busy_nxt_o  (busy_nxt[g])
    );
  end

  always_comb begin
    overrun_d = overrun_q | (edge_det & ~i_retrig_en & (|armed));
    busy_d    = |busy_nxt;
  end

  // prev_q resets high so a request already asserted at reset release is not an edge.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      prev_q     <= 1'b1;
      sys_sync_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      prev_q     <= i_sync;
      sys_sync_q <= edge_det;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_sys_sync = sys_sync_q;
  assign o_busy     = busy_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_sync_strobe_gen.sv
// Bench for sync_strobe_gen: an aligned and a free-running instance share stimulus
// and are compared every cycle against an event-level reference model.
module tb_sync_strobe_gen;

  localparam int CH    = 3;
  localparam int DIV_W = 8;
  localparam int DLY_W = 16;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic                   in_rst, in_sync, in_retrig;
  logic [CH*DIV_W-1:0]    in_div;
  logic [CH*DLY_W-1:0]    in_dly;
  logic [CH-1:0]          a_ce, a_sync, b_ce, b_sync;
  logic                   a_sys, a_busy, a_ovr, b_sys, b_busy, b_ovr;

  sync_strobe_gen #(.CHANNELS(CH), .DIV_W(DIV_W), .DLY_W(DLY_W), .ALIGN(1)) u_dut_a (
    .sys_clk(sys_clk), .rst(in_rst), .i_sync(in_sync), .i_retrig_en(in_retrig),
    .i_div(in_div), .i_dly(in_dly), .o_ce(a_ce), .o_sync(a_sync),
    .o_sys_sync(a_sys), .o_busy(a_busy), .o_overrun(a_ovr)
  );

  sync_strobe_gen #(.CHANNELS(CH), .DIV_W(DIV_W), .DLY_W(DLY_W), .ALIGN(0)) u_dut_b (
    .sys_clk(sys_clk), .rst(in_rst), .i_sync(in_sync), .i_retrig_en(in_retrig),
    .i_div(in_div), .i_dly(in_dly), .o_ce(b_ce), .o_sync(b_sync),
    .o_sys_sync(b_sys), .o_busy(b_busy), .o_overrun(b_ovr)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference state, index 0 = aligned instance, 1 = free-running instance.
  // m_need = CE ticks still to observe, the last one carries the strobe.
  bit            m_prev;
  bit            m_pend [2][CH];
  int            m_need [2][CH];
  int            m_last [2][CH];
  logic [CH-1:0] e_ce   [2];
  logic [CH-1:0] e_sync [2];
  logic          e_sys  [2];
  logic          e_busy [2];
  logic          e_ovr  [2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
  endtask

  function automatic int get_div(input int ch);
    return int'(in_div[ch*DIV_W +: DIV_W]);
  endfunction

  function automatic int get_dly(input int ch);
    return int'(in_dly[ch*DLY_W +: DLY_W]);
  endfunction

  task automatic set_div(input int ch, input int v);
    in_div[ch*DIV_W +: DIV_W] = DIV_W'(v);
  endtask

  task automatic set_dly(input int ch, input int v);
    in_dly[ch*DLY_W +: DLY_W] = DLY_W'(v);
  endtask

  // Expected outputs for cycle cyc from the inputs held during cycle cyc-1.
  task automatic model_step();
    bit edge_seen;
    bit ce;
    int neff;
    edge_seen = !in_rst && in_sync && !m_prev;
    for (int d = 0; d < 2; d++) begin
      e_ce[d]   = '0;
      e_sync[d] = '0;
      e_busy[d] = 1'b0;
      if (in_rst) begin
        e_sys[d] = 1'b0;
        e_ovr[d] = 1'b0;
        for (int ch = 0; ch < CH; ch++) begin
          m_pend[d][ch] = 1'b0;
          m_need[d][ch] = 0;
          m_last[d][ch] = cyc;
        end
      end else begin
        e_sys[d] = edge_seen;
        for (int ch = 0; ch < CH; ch++) begin
          if (edge_seen) begin
            if (m_pend[d][ch] && !in_retrig) begin
              e_ovr[d] = 1'b1;
            end else begin
              m_pend[d][ch] = 1'b1;
              m_need[d][ch] = get_dly(ch) + 1;
            end
          end
          neff = (get_div(ch) == 0) ? 1 : get_div(ch);
          ce = (d == 0 && edge_seen) || (cyc - m_last[d][ch] >= neff);
          if (ce) begin
            e_ce[d][ch]   = 1'b1;
            m_last[d][ch] = cyc;
            if (m_pend[d][ch]) begin
              m_need[d][ch]--;
              if (m_need[d][ch] == 0) begin
                e_sync[d][ch] = 1'b1;
                m_pend[d][ch] = 1'b0;
              end
            end
          end
          if (m_pend[d][ch] || e_sync[d][ch]) e_busy[d] = 1'b1;
        end
      end
    end
    m_prev = in_rst ? 1'b1 : in_sync;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    model_step();
    check_eq("a_ce",       32'(a_ce),   32'(e_ce[0]));
    check_eq("a_sync",     32'(a_sync), 32'(e_sync[0]));
    check_eq("a_sys_sync", 32'(a_sys),  32'(e_sys[0]));
    check_eq("a_busy",     32'(a_busy), 32'(e_busy[0]));
    check_eq("a_overrun",  32'(a_ovr),  32'(e_ovr[0]));
    check_eq("b_ce",       32'(b_ce),   32'(e_ce[1]));
    check_eq("b_sync",     32'(b_sync), 32'(e_sync[1]));
    check_eq("b_sys_sync", 32'(b_sys),  32'(e_sys[1]));
    check_eq("b_busy",     32'(b_busy), 32'(e_busy[1]));
    check_eq("b_overrun",  32'(b_ovr),  32'(e_ovr[1]));
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int   t_fire [CH];
    bit   busy_hist [16];
    bit   got;
    bit   all_hi;
    bit   any_sync;
    logic [4:0] pat;

    in_rst = 1'b1; in_sync = 1'b0; in_retrig = 1'b0; in_div = '0; in_dly = '0;
    set_div(0, 1); set_div(1, 4); set_div(2, 8);
    tick_n(2);
    check_eq("rst_outputs", 32'({a_ce, a_sync, a_sys, a_busy, a_ovr}), 32'd0);
    in_rst = 1'b0;
    tick_n(5);

    // Zero delay: every channel strobes on the aligned CE right after the edge.
    in_sync = 1'b1; tick(); in_sync = 1'b0;
    check_eq("s1_sys_sync", 32'(a_sys), 32'd1);
    check_eq("s1_sync_all", 32'(a_sync), 32'd7);
    check_eq("s1_ce_all",   32'(a_ce),   32'd7);
    tick_n(12);

    set_dly(0, 3); set_dly(1, 2); set_dly(2, 1);
    for (int ch = 0; ch < CH; ch++) t_fire[ch] = -1;
    in_sync = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      in_sync = 1'b0;
      for (int ch = 0; ch < CH; ch++)
        if (a_sync[ch] && t_fire[ch] < 0) t_fire[ch] = k;
      busy_hist[k] = a_busy;
    end
    check_eq("s2_fire_ch0", 32'(t_fire[0]), 32'd4);
    check_eq("s2_fire_ch1", 32'(t_fire[1]), 32'd9);
    check_eq("s2_fire_ch2", 32'(t_fire[2]), 32'd9);
    all_hi = 1'b1;
    for (int k = 1; k <= 9; k++) all_hi &= busy_hist[k];
    check_eq("s2_busy_span", 32'(all_hi), 32'd1);
    check_eq("s2_busy_drop", 32'(busy_hist[10]), 32'd0);

    // Free-running instance: edge placed so its next ch1 CE is 3 cycles out.
    set_dly(1, 0);
    tick_n(10);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      got = b_ce[1];
    end
    check_eq("s3_wait_ce", 32'(got), 32'd1);
    tick();
    in_sync = 1'b1; tick(); in_sync = 1'b0;
    check_eq("s3_sync_t1", 32'(b_sync[1]), 32'd0);
    tick();
    check_eq("s3_sync_t2", 32'(b_sync[1]), 32'd0);
    tick();
    check_eq("s3_sync_t3", 32'(b_sync[1]), 32'd1);
    check_eq("s3_ce_t3",   32'(b_ce[1]),   32'd1);

    // Retrigger: second edge 4 cycles after the first.
    tick_n(20);
    set_div(0, 2); set_dly(0, 5); set_dly(1, 0); set_dly(2, 0);
    for (int pass = 0; pass < 2; pass++) begin
      in_retrig = (pass == 0);
      in_sync = 1'b1; tick(); in_sync = 1'b0;
      tick_n(3);
      in_sync = 1'b1; tick(); in_sync = 1'b0;
      check_eq("s4_second_sys_sync", 32'(a_sys), 32'd1);
      t_fire[0] = -1;
      for (int k = 1; k <= 14; k++) begin
        tick();
        if (a_sync[0] && t_fire[0] < 0) t_fire[0] = k;
      end
      if (pass == 0) begin
        check_eq("s4_retrig_fire", 32'(t_fire[0]), 32'd10);
        check_eq("s4_retrig_ovr",  32'(a_ovr),     32'd0);
      end else begin
        check_eq("s4_noretrig_fire", 32'(t_fire[0]), 32'd6);
        check_eq("s4_noretrig_ovr",  32'(a_ovr),     32'd1);
      end
      tick_n(10);
    end

    // Request held high across reset release is not an edge; reset clears overrun.
    in_sync = 1'b1; in_rst = 1'b1;
    tick_n(2);
    in_rst = 1'b0;
    check_eq("s5_ovr_cleared", 32'(a_ovr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("s5_no_sys_sync", 32'(a_sys), 32'd0);
    end
    in_sync = 1'b0; tick();
    set_div(0, 1); set_dly(0, 20);
    in_sync = 1'b1; tick(); in_sync = 1'b0;
    tick();
    check_eq("s5_busy_armed", 32'(a_busy), 32'd1);
    in_rst = 1'b1; tick(); in_rst = 1'b0;
    check_eq("s5_busy_after_rst", 32'(a_busy), 32'd0);
    any_sync = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      any_sync |= a_sync[0];
    end
    check_eq("s5_no_late_sync", 32'(any_sync), 32'd0);

    // Divide by zero ticks every cycle; shrinking the ratio mid-phase never stalls.
    set_div(2, 0);
    tick();
    all_hi = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      all_hi &= a_ce[2] & b_ce[2];
    end
    check_eq("s6_div0_every_cycle", 32'(all_hi), 32'd1);
    set_div(1, 8);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      got = b_ce[1];
    end
    check_eq("s6_wait_ce", 32'(got), 32'd1);
    tick_n(5);
    set_div(1, 2);
    for (int k = 0; k < 5; k++) begin
      tick();
      pat[k] = b_ce[1];
    end
    check_eq("s6_div_8_to_2", 32'(pat), 32'h15);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      in_rst    = ($urandom_range(0, 299) == 0);
      in_retrig = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) in_sync = ~in_sync;
      if ($urandom_range(0, 19) == 0)
        set_div(int'($urandom_range(0, CH-1)), int'($urandom_range(0, 6)));
      if ($urandom_range(0, 9) == 0)
        set_dly(int'($urandom_range(0, CH-1)), int'($urandom_range(0, 5)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
